// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer: FSM states and reset vector.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sl2.sv
// Shift-left-by-two; turns a word offset into a byte offset.
// Latency: combinational. Backpressure: none.
module sl2 #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  output logic [n-1:0] y
);

  assign y = a << 2;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetches and picks the next pc (jr > jmp > branch > pc+4).
// Latency: one cycle from an advance cycle to the new pc. Backpressure: holds on !imem_ack, parks in HOLD on stall.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = (n)'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         imem_ack,
  input  logic         br_taken,
  input  logic [15:0]  br_imm,
  input  logic         jmp,
  input  logic [25:0]  jmp_idx,
  input  logic         jr,
  input  logic [n-1:0] jr_addr,
  output logic         imem_req,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         instr_valid,
  output logic         misalign
);

  state_t       state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic         imem_req_q, imem_req_d;
  logic         instr_valid_q, instr_valid_d;
  logic         misalign_q, misalign_d;

  logic         accept;
  logic         advance;
  logic [n-1:0] br_ext;
  logic [n-1:0] br_off;
  logic [n-1:0] br_tgt;
  logic [n-1:0] jmp_tgt;
  logic [n-1:0] jr_tgt;

  assign pc_plus4 = pc_q + (n)'(4);

  assign br_ext = {{(n-16){br_imm[15]}}, br_imm};

  sl2 #(.n(n)) u_sl2 (
    .a (br_ext),
    .y (br_off)
  );

  assign br_tgt  = pc_plus4 + br_off;
  assign jmp_tgt = {pc_plus4[n-1:28], jmp_idx, 2'b00};
  assign jr_tgt  = {jr_addr[n-1:2], 2'b00};

  // Control inputs only matter on the cycle the pc actually moves.
  always_comb begin
    accept        = (state_q == FETCH) && imem_ack;
    advance       = (accept && !stall) || ((state_q == HOLD) && !stall);
    state_d       = state_q;
    pc_d          = pc_q;

    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = stall ? HOLD : FETCH;
      HOLD:    if (!stall) state_d = FETCH;
      default: state_d = BOOT;
    endcase

    if (advance) begin
      if (jr)            pc_d = jr_tgt;
      else if (jmp)      pc_d = jmp_tgt;
      else if (br_taken) pc_d = br_tgt;
      else               pc_d = pc_plus4;
    end

    imem_req_d    = (state_d == FETCH);
    instr_valid_d = accept;
    misalign_d    = advance && jr && (jr_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc          = pc_q;
  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter n, default 32: datapath/address width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1: downstream hold; freezes PC advance while high.
REQ-006 SHALL have port imem_ack  input  1: instruction memory accepted the current fetch this cycle.
REQ-007 SHALL have port br_taken  input  1: conditional branch resolved taken.
REQ-008 SHALL have port br_imm  input  16: signed branch word offset.
REQ-009 SHALL have port jmp  input  1: absolute jump request.
REQ-010 SHALL have port jmp_idx  input  26: jump word index.
REQ-011 SHALL have port jr  input  1: register-indirect jump request.
REQ-012 SHALL have port jr_addr  input  n: register jump byte address.
REQ-013 SHALL have port imem_req  output  1: fetch request, valid for current pc.
REQ-014 SHALL have port pc  output  n: current fetch address.
REQ-015 SHALL have port pc_plus4  output  n: pc + 4, combinational from pc.
REQ-016 SHALL have port instr_valid  output  1: one-cycle pulse when fetch at pc is acknowledged.
REQ-017 SHALL have port misalign  output  1: one-cycle pulse when an accepted jr_addr has nonzero bits [1:0].

Function
REQ-018 SHALL implement states BOOT, FETCH, HOLD.
REQ-019 SHALL go BOOT -> FETCH unconditionally one cycle after reset release; imem_req = 0 in BOOT.
REQ-020 SHALL drive imem_req = 1 only in FETCH; imem_req SHALL NOT depend combinationally on imem_ack.
REQ-021 SHALL in FETCH with imem_ack = 0 hold pc and remain in FETCH.
REQ-022 SHALL in FETCH with imem_ack = 1 pulse instr_valid; stall = 0 -> advance pc, stay FETCH; stall = 1 -> hold pc, go HOLD.
REQ-023 SHALL in HOLD keep imem_req = 0 and pc constant; when stall falls to 0, advance pc in that cycle and go FETCH.
REQ-024 SHALL sample br_taken/jmp/jr and operands only in advance cycles; ignore them otherwise.
REQ-025 SHALL select next pc with priority jr > jmp > br_taken > sequential.
REQ-026 SHALL compute sequential target = pc_plus4.
REQ-027 SHALL compute branch target = pc_plus4 + (sign-extended br_imm shifted left 2); bits shifted past bit n-1 dropped; sum wraps modulo 2^n.
REQ-028 SHALL compute jump target = {pc_plus4[n-1:28], jmp_idx, 2'b00}.
REQ-029 SHALL compute jr target = {jr_addr[n-1:2], 2'b00} and pulse misalign when jr_addr[1:0] != 0 in the accepting advance cycle.
REQ-030 SHALL wrap pc_plus4 from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-031 SHALL give one-cycle latency: target selected in an advance cycle appears on pc the next cycle.

Reset
REQ-032 SHALL on rst_n = 0 immediately force state = BOOT, pc = RESET_PC, imem_req = 0, instr_valid = 0, misalign = 0, independent of clk.
REQ-033 SHALL abort any outstanding fetch when reset asserts mid-FETCH/HOLD; no instr_valid pulse after reset until a new imem_ack in FETCH.
REQ-034 SHALL leave BOOT only on the first rising clk edge with rst_n = 1.

Structure
REQ-035 SHALL place the state enumeration (BOOT, FETCH, HOLD) and the default RESET_PC constant in the shared CPU package.
REQ-036 SHALL instantiate the existing sl2 module (n = 32) on the sign-extended br_imm as its single sub-module; no other sub-modules.

Verification
REQ-037 SHALL cover reset: RESET_PC = 0x0000_0000, rst_n released, imem_ack = 1, stall = 0 -> BOOT 1 cycle, then pc = 0x0, 0x4, 0x8 on consecutive cycles, one instr_valid each.
REQ-038 SHALL cover branch: pc = 0x100, br_taken = 1, br_imm = 16'hFFFE, ack -> next pc = 0x0FC; br_imm = 0x0003 -> 0x110.
REQ-039 SHALL cover priority: pc = 0x200, jr = 1, jr_addr = 0x1003, jmp = 1, br_taken = 1, ack -> pc = 0x1000, misalign pulses once.
REQ-040 SHALL cover jump: pc = 0x8000_0010, jmp_idx = 26'h0000040 -> next pc = 0x8000_0100.
REQ-041 SHALL cover stall/handshake: ack withheld 3 cycles -> pc and imem_req held; ack with stall = 1 for 2 cycles -> HOLD, imem_req = 0, single instr_valid, pc advances on stall fall.
REQ-042 SHALL cover wrap and async reset: pc = 0xFFFF_FFFC sequential -> 0x0; rst_n dropped mid-HOLD -> pc = RESET_PC before next clk edge.
